// File: rtl/m_div_controller.sv
// m_div_controller: sequencing FSM for a restoring divider datapath.
// Drives the remainder/divisor/quotient select lines through LOAD, ITERATIONS
// shift/subtract steps and DONE, and reports sign-fixup and divide-by-zero
// flags for the result stage.
// Optional build macro: M_DIV_DBZ_BYPASS_EN -- a divide by zero skips the
// iteration phase and goes straight from LOAD to DONE.
module m_div_controller #(
    parameter int ITERATIONS = 32,
    parameter int CNT_W      = $clog2(ITERATIONS + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_signed,
    input  logic       rs1_neg,
    input  logic       rs2_neg,
    input  logic       rs2_zero,
    output logic [1:0] muxR,
    output logic [1:0] muxD,
    output logic [1:0] muxZ,
    output logic       busy,
    output logic       done,
    output logic       neg_quot,
    output logic       neg_rem,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] R_KEEP     = 2'd0;
    localparam logic [1:0] R_A        = 2'd1;
    localparam logic [1:0] R_A_NEG    = 2'd2;
    localparam logic [1:0] R_SUB_KEEP = 2'd3;

    localparam logic [1:0] D_KEEP     = 2'd0;
    localparam logic [1:0] D_B        = 2'd1;
    localparam logic [1:0] D_B_NEG    = 2'd2;
    localparam logic [1:0] D_SHR      = 2'd3;

    localparam logic [1:0] Z_KEEP     = 2'd0;
    localparam logic [1:0] Z_ZERO     = 2'd1;
    localparam logic [1:0] Z_SHL_ADD  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Operand attributes captured when a request is accepted.
    logic s_sgn;
    logic s_n1;
    logic s_n2;
    logic s_z;

    logic accept;

    assign accept = (state_q == S_IDLE) && start;

    // State register and iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the sign/zero attributes of the operation being accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_sgn <= 1'b0;
            s_n1  <= 1'b0;
            s_n2  <= 1'b0;
            s_z   <= 1'b0;
        end else if (accept) begin
            s_sgn <= is_signed;
            s_n1  <= rs1_neg;
            s_n2  <= rs2_neg;
            s_z   <= rs2_zero;
        end
    end

    // Result-stage flags: cleared by a new request, loaded on entry to DONE,
    // then held so the result stage can read them after the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
            div_by_zero <= 1'b0;
        end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            // A zero divisor yields all-ones quotient, which is never negated.
            neg_quot    <= s_sgn & (s_n1 ^ s_n2) & ~s_z;
            neg_rem     <= s_sgn & s_n1;
            div_by_zero <= s_z;
        end
    end

    // Next-state, counter and Moore select decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        muxR    = R_KEEP;
        muxD    = D_KEEP;
        muxZ    = Z_KEEP;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                muxR  = (s_sgn & s_n1) ? R_A_NEG : R_A;
                muxD  = (s_sgn & s_n2) ? D_B_NEG : D_B;
                muxZ  = Z_ZERO;
                busy  = 1'b1;
                cnt_d = '0;
`ifdef M_DIV_DBZ_BYPASS_EN
                state_d = s_z ? S_DONE : S_ITER;
`else
                state_d = S_ITER;
`endif
            end

            S_ITER: begin
                muxR  = R_SUB_KEEP;
                muxD  = D_SHR;
                muxZ  = Z_SHL_ADD;
                busy  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_m_div_controller.sv
// tb_m_div_controller: self-checking bench for m_div_controller.
// A cycle-offset reference model predicts every output each cycle; directed
// operations pin latency, LOAD selects and flags with literal values, then a
// randomized phase exercises starts, ignored starts and occasional resets.
module tb_m_div_controller;

    localparam int N = 32;
`ifdef M_DIV_DBZ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DBZ_LAT = BYP ? 2 : 34;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       is_signed = 1'b0;
    logic       rs1_neg = 1'b0;
    logic       rs2_neg = 1'b0;
    logic       rs2_zero = 1'b0;
    logic [1:0] muxR;
    logic [1:0] muxD;
    logic [1:0] muxZ;
    logic       busy;
    logic       done;
    logic       neg_quot;
    logic       neg_rem;
    logic       div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    m_div_controller #(.ITERATIONS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .rs1_neg     (rs1_neg),
        .rs2_neg     (rs2_neg),
        .rs2_zero    (rs2_zero),
        .muxR        (muxR),
        .muxD        (muxD),
        .muxZ        (muxZ),
        .busy        (busy),
        .done        (done),
        .neg_quot    (neg_quot),
        .neg_rem     (neg_rem),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: an accepted request occupies cycles 1..m_len after
    // the accepting cycle; cycle 1 is LOAD, cycle m_len is DONE.
    bit m_act = 1'b0;
    int m_off = 0;
    int m_len = 0;
    bit m_sgn, m_n1, m_n2, m_z;
    bit e_nq = 1'b0, e_nr = 1'b0, e_dz = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 1'b0;
            m_off = 0;
            e_nq  = 1'b0;
            e_nr  = 1'b0;
            e_dz  = 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_sgn = is_signed;
                m_n1  = rs1_neg;
                m_n2  = rs2_neg;
                m_z   = rs2_zero;
                m_act = 1'b1;
                m_off = 1;
                m_len = (BYP && rs2_zero) ? 2 : N + 2;
                e_nq  = 1'b0;
                e_nr  = 1'b0;
                e_dz  = 1'b0;
            end
        end else if (m_off == m_len) begin
            m_act = 1'b0;
        end else begin
            m_off++;
            if (m_off == m_len) begin
                e_nq = m_sgn && (m_n1 != m_n2) && !m_z;
                e_nr = m_sgn && m_n1;
                e_dz = m_z;
            end
        end
    end

    logic [1:0]  e_r, e_d, e_z;
    logic        e_busy, e_done;
    logic [10:0] act_v, exp_v;

    always @(negedge clk) begin
        if (chk_en) begin
            e_r = 2'd0; e_d = 2'd0; e_z = 2'd0; e_busy = 1'b0; e_done = 1'b0;
            if (m_act) begin
                e_busy = 1'b1;
                if (m_off == 1) begin
                    e_r = (m_sgn && m_n1) ? 2'd2 : 2'd1;
                    e_d = (m_sgn && m_n2) ? 2'd2 : 2'd1;
                    e_z = 2'd1;
                end else if (m_off == m_len) begin
                    e_done = 1'b1;
                end else begin
                    e_r = 2'd3; e_d = 2'd3; e_z = 2'd2;
                end
            end
            act_v = {muxR, muxD, muxZ, busy, done, neg_quot, neg_rem, div_by_zero};
            exp_v = {e_r, e_d, e_z, e_busy, e_done, e_nq, e_nr, e_dz};
            check("cycle_outputs", 32'(act_v), 32'(exp_v));
        end
    end

    // One operation: start in the current cycle, optional spurious starts at
    // offsets 5 and 33, wait (bounded) for done and pin latency/selects/flags.
    task automatic run_op(input bit sg, input bit n1, input bit n2, input bit z,
                          input logic [5:0] exp_load, input int exp_lat,
                          input logic [2:0] exp_flags, input bit inject);
        int s_cyc;
        bit got;
        int lat;
        @(posedge clk); #1;
        start = 1'b1; is_signed = sg; rs1_neg = n1; rs2_neg = n2; rs2_zero = z;
        s_cyc = cyc;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k < 200 && !got; k++) begin
            @(posedge clk); #1;
            start     = inject && (k == 5 || k == 33);
            is_signed = 1'($urandom);
            rs1_neg   = 1'($urandom);
            rs2_neg   = 1'($urandom);
            rs2_zero  = 1'($urandom);
            @(negedge clk);
            if (k == 1) check("load_selects", 32'({muxR, muxD, muxZ}), 32'(exp_load));
            if (done) begin
                got = 1'b1;
                lat = cyc - s_cyc;
            end
        end
        check("done_seen", 32'(got), 32'(1));
        check("done_latency", 32'(lat), 32'(exp_lat));
        check("done_flags", 32'({neg_quot, neg_rem, div_by_zero}), 32'(exp_flags));
    endtask

    initial begin
        #2 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_state",
                 32'({muxR, muxD, muxZ, busy, done, neg_quot, neg_rem, div_by_zero}), 32'(0));
        #2 reset = 1'b0;

        // Unsigned with ignored starts, then back-to-back signed operations.
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 6'b01_01_01, 34, 3'b000, 1'b1);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 6'b10_01_01, 34, 3'b110, 1'b0);
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 6'b10_10_01, 34, 3'b010, 1'b0);
        repeat (3) @(negedge clk);
        check("flags_hold", 32'({neg_quot, neg_rem, div_by_zero}), 32'(3'b010));

        // Divide by zero, unsigned and signed (quotient negation suppressed).
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 6'b01_01_01, DBZ_LAT, 3'b001, 1'b0);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 6'b10_01_01, DBZ_LAT, 3'b011, 1'b0);

        // Asynchronous reset during ITER cycle 10.
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b1; rs1_neg = 1'b1; rs2_neg = 1'b0; rs2_zero = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1 check("async_reset_outputs",
                 32'({muxR, muxD, muxZ, busy, done, neg_quot, neg_rem, div_by_zero}), 32'(0));
        @(posedge clk); #3 reset = 1'b0;
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 6'b01_01_01, 34, 3'b000, 1'b0);

        // Randomized traffic: frequent start pulses, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start     = ($urandom_range(0, 5) == 0);
            is_signed = 1'($urandom);
            rs1_neg   = 1'($urandom);
            rs2_neg   = 1'($urandom);
            rs2_zero  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                @(posedge clk); #3 reset = 1'b0;
            end
        end
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
